// File: rtl/xt_bus_pkg.sv
// Shared bus-slave definitions: FSM states, register map and FIFO_STAT byte layout.
// Imported by every block that decodes the slave register window.
package xt_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } wb_state_t;

  localparam logic [7:0] ADR_CTRL      = 8'h00;
  localparam logic [7:0] ADR_STATUS    = 8'h01;
  localparam logic [7:0] ADR_DATA      = 8'h02;
  localparam logic [7:0] ADR_FIFO_STAT = 8'h03;
  localparam logic [7:0] ADR_SCRATCH   = 8'h04;
  localparam int         NUM_SCRATCH   = 4;

  function automatic logic [7:0] pack_fifo_stat(input logic       ovf,
                                                input logic [2:0] cnt,
                                                input logic       full,
                                                input logic       empty);
    return {ovf, cnt, 2'b00, full, empty};
  endfunction

endpackage

// File: rtl/wb_rx_fifo.sv
// Receive FIFO: push/pop take effect at the clock edge, head data is combinational.
// Push while full is refused unless a pop happens in the same cycle; pop on empty is ignored.
module wb_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // When full, a simultaneous pop frees the head slot, which is exactly where wr_ptr points.
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/wishbone_slave_regs.sv
// Wishbone classic register slave with RX FIFO; ack WAIT_STATES+1 cycles after stb is sampled.
// Master holds cyc/stb until ack; dropping them before ack aborts with no side effect.
module wishbone_slave_regs
  import xt_bus_pkg::*;
#(
  parameter int PORT_SIZE   = 8,
  parameter int WAIT_STATES = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [PORT_SIZE-1:0] wb_adr_i,
  input  logic [PORT_SIZE-1:0] wb_dat_i,
  output logic [PORT_SIZE-1:0] wb_dat_o,
  output logic                 wb_ack_o,
  output logic [7:0]           ctrl_o,
  input  logic [7:0]           status_i,
  input  logic                 dev_push_i,
  input  logic [7:0]           dev_data_i,
  output logic                 fifo_full_o,
  output logic                 irq_o
);

  localparam int         CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [1:0] WS_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  wb_state_t     state_q;
  wb_state_t     state_d;
  logic [1:0]    wait_cnt_q;
  logic [1:0]    wait_cnt_d;
  logic          load_dat;
  logic          req;
  logic          commit_wr;

  logic [7:0]    ctrl_q;
  logic [7:0]    scratch_q [NUM_SCRATCH];
  logic          ovf_q;

  logic          hit_ctrl;
  logic          hit_status;
  logic          hit_data;
  logic          hit_fstat;
  logic          hit_scratch;
  logic [7:0]    rd_byte;
  logic [7:0]    wr_byte;

  logic          fifo_pop;
  logic [7:0]    fifo_dat;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [2:0]    stat_cnt;

  assign req         = wb_cyc_i & wb_stb_i;
  assign hit_ctrl    = (wb_adr_i == PORT_SIZE'(ADR_CTRL));
  assign hit_status  = (wb_adr_i == PORT_SIZE'(ADR_STATUS));
  assign hit_data    = (wb_adr_i == PORT_SIZE'(ADR_DATA));
  assign hit_fstat   = (wb_adr_i == PORT_SIZE'(ADR_FIFO_STAT));
  assign hit_scratch = ((wb_adr_i >> 2) == PORT_SIZE'(ADR_SCRATCH >> 2));
  assign wr_byte     = wb_dat_i[7:0];
  assign stat_cnt    = 3'(fifo_count);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    load_dat   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d  = ST_ACK;
            load_dat = 1'b1;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = WS_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_q == 2'd0) begin
          state_d  = ST_ACK;
          load_dat = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_byte = 8'h00;
    if (hit_ctrl)         rd_byte = ctrl_q;
    else if (hit_status)  rd_byte = status_i;
    else if (hit_data)    rd_byte = fifo_empty ? 8'h00 : fifo_dat;
    else if (hit_fstat)   rd_byte = pack_fifo_stat(ovf_q, stat_cnt, fifo_full, fifo_empty);
    else if (hit_scratch) rd_byte = scratch_q[wb_adr_i[1:0]];
  end

  // All register side effects happen only on the edge that closes a visible ack.
  assign wb_ack_o  = (state_q == ST_ACK) & req;
  assign commit_wr = wb_ack_o & wb_we_i;
  assign fifo_pop  = wb_ack_o & ~wb_we_i & hit_data;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      wb_dat_o <= '0;
      ctrl_q   <= 8'h00;
      ovf_q    <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= 8'h00;
    end else begin
      if (load_dat)                 wb_dat_o                   <= PORT_SIZE'(rd_byte);
      if (commit_wr && hit_ctrl)    ctrl_q                     <= wr_byte;
      if (commit_wr && hit_scratch) scratch_q[wb_adr_i[1:0]]   <= wr_byte;
      if (commit_wr && hit_fstat && wr_byte[7]) ovf_q <= 1'b0;
      // A dropped byte in the same cycle as a clear still leaves ovf set.
      if (dev_push_i && fifo_full && !fifo_pop) ovf_q <= 1'b1;
    end
  end

  wb_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_i),
    .push     (dev_push_i),
    .push_dat (dev_data_i),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign ctrl_o      = ctrl_q;
  assign fifo_full_o = fifo_full;
  assign irq_o       = (ctrl_q[0] & ~fifo_empty) | (ctrl_q[1] & ovf_q);

endmodule

// File: tb/tb_wishbone_slave_regs.sv
// Bench for wishbone_slave_regs: three instances (WAIT_STATES 1, 0, 3) share one clock and reset.
module tb_wishbone_slave_regs;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      cyc, stb, we, push;
  logic [2:0][7:0] adr, wdat, status, ddat;
  logic [2:0][7:0] rdat, ctrl;
  logic [2:0]      ack, full, irq;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_cnt  = 0;

  typedef struct {
    int         dut;
    bit         is_rd;
    logic [7:0] dat;
    int         cyc;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wishbone_slave_regs #(
      .PORT_SIZE   (8),
      .WAIT_STATES (g == 0 ? 1 : (g == 1 ? 0 : 3)),
      .FIFO_DEPTH  (4)
    ) u_dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst_n),
      .wb_cyc_i    (cyc[g]),
      .wb_stb_i    (stb[g]),
      .wb_we_i     (we[g]),
      .wb_adr_i    (adr[g]),
      .wb_dat_i    (wdat[g]),
      .wb_dat_o    (rdat[g]),
      .wb_ack_o    (ack[g]),
      .ctrl_o      (ctrl[g]),
      .status_i    (status[g]),
      .dev_push_i  (push[g]),
      .dev_data_i  (ddat[g]),
      .fifo_full_o (full[g]),
      .irq_o       (irq[g])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", nm, act, exp);
  endtask

  // Monitor: every ack pops one expectation and checks instance, latency and read data.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (ack[d] === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_ack dut=%0d got ack=1 want ack=0", d);
        end else begin
          e = sb_q.pop_front();
          chk("ack_dut", d, e.dut);
          chk("ack_latency", cyc_cnt, e.cyc);
          if (e.is_rd) chk("rd_data", {24'd0, rdat[d]}, {24'd0, e.dat});
        end
      end
    end
  end

  task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                      input logic [7:0] exp_rd, input bit hold_cyc,
                      input bit push_at_ack, input logic [7:0] push_byte);
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = wr; adr[d] = a; wdat[d] = wd;
    e.dut = d; e.is_rd = !wr; e.dat = exp_rd; e.cyc = cyc_cnt + ws_of(d) + 1;
    sb_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ack[d] === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL ack_timeout dut=%0d adr=%02h got no ack want ack", d, a);
      sb_q.delete(sb_q.size() - 1);
    end else if (push_at_ack) begin
      push[d] = 1'b1; ddat[d] = push_byte;
    end
    @(posedge clk); #1;
    stb[d] = 1'b0; we[d] = 1'b0; push[d] = 1'b0;
    if (!hold_cyc) cyc[d] = 1'b0;
  endtask

  task automatic wr(input int d, input logic [7:0] a, input logic [7:0] v);
    xfer(d, 1'b1, a, v, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic rd(input int d, input logic [7:0] a, input logic [7:0] exp);
    xfer(d, 1'b0, a, 8'h00, exp, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic dev_push(input int d, input logic [7:0] b);
    @(posedge clk); #1; push[d] = 1'b1; ddat[d] = b;
    @(posedge clk); #1; push[d] = 1'b0;
  endtask

  task automatic watch_no_ack(input int d, input int n, input string nm);
    bit saw = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ack[d] === 1'b1) saw = 1'b1;
    end
    chk(nm, saw, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    cyc = '0; stb = '0; we = '0; push = '0;
    adr = '0; wdat = '0; ddat = '0;
    status[0] = 8'hA5; status[1] = 8'h3C; status[2] = 8'h96;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_ack",  ack[d],  1'b0);
      chk("rst_ctrl", ctrl[d], 8'h00);
      chk("rst_irq",  irq[d],  1'b0);
      chk("rst_full", full[d], 1'b0);
      chk("rst_dat",  rdat[d], 8'h00);
    end

    // WAIT_STATES=1: scratch round trip, status, unmapped address
    wr(0, 8'h04, 8'h5A);
    rd(0, 8'h04, 8'h5A);
    chk("ctrl_after_scratch", ctrl[0], 8'h00);
    rd(0, 8'h01, 8'hA5);
    wr(0, 8'h07, 8'hC3);
    rd(0, 8'h07, 8'hC3);
    rd(0, 8'h04, 8'h5A);
    wr(0, 8'h10, 8'hFF);
    rd(0, 8'h10, 8'h00);

    // WAIT_STATES=0: read-modify-write on CTRL with a one-cycle stb gap
    xfer(1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
    wr(1, 8'h00, 8'h03);
    chk("rmw_ctrl", ctrl[1], 8'h03);

    // Fill past full: overflow is sticky and the dropped byte never appears
    dev_push(1, 8'h11); dev_push(1, 8'h22); dev_push(1, 8'h33);
    chk("full_at_3", full[1], 1'b0);
    dev_push(1, 8'h44);
    chk("full_at_4", full[1], 1'b1);
    dev_push(1, 8'h55);
    rd(1, 8'h03, 8'hC2);
    rd(1, 8'h02, 8'h11);
    chk("full_after_pop", full[1], 1'b0);
    rd(1, 8'h02, 8'h22);
    rd(1, 8'h02, 8'h33);
    rd(1, 8'h02, 8'h44);
    rd(1, 8'h02, 8'h00);
    rd(1, 8'h03, 8'h81);
    wr(1, 8'h00, 8'h02);
    chk("irq_ovf", irq[1], 1'b1);
    wr(1, 8'h03, 8'h80);
    chk("irq_ovf_clr", irq[1], 1'b0);
    rd(1, 8'h03, 8'h01);

    // Full FIFO: push and DATA pop commit on the same edge
    dev_push(0, 8'hA1); dev_push(0, 8'hA2); dev_push(0, 8'hA3); dev_push(0, 8'hA4);
    chk("full0", full[0], 1'b1);
    xfer(0, 1'b0, 8'h02, 8'h00, 8'hA1, 1'b0, 1'b1, 8'hB5);
    chk("full_pushpop", full[0], 1'b1);
    rd(0, 8'h03, 8'h42);
    rd(0, 8'h02, 8'hA2);
    rd(0, 8'h02, 8'hA3);
    rd(0, 8'h02, 8'hA4);
    rd(0, 8'h02, 8'hB5);
    rd(0, 8'h03, 8'h01);

    // Non-empty interrupt
    wr(0, 8'h00, 8'h01);
    chk("irq_empty", irq[0], 1'b0);
    dev_push(0, 8'h77);
    chk("irq_data", irq[0], 1'b1);
    rd(0, 8'h02, 8'h77);
    chk("irq_popped", irq[0], 1'b0);

    // WAIT_STATES=3: abort a DATA read during WAIT, then serve normally
    dev_push(2, 8'h99);
    @(posedge clk); #1;
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; adr[2] = 8'h02;
    repeat (2) @(posedge clk);
    #1 cyc[2] = 1'b0; stb[2] = 1'b0;
    watch_no_ack(2, 6, "abort_no_ack");
    rd(2, 8'h03, 8'h10);
    rd(2, 8'h02, 8'h99);

    // Reset while in WAIT: no ack, everything back to reset values
    wr(2, 8'h00, 8'h03);
    wr(2, 8'h05, 8'hEE);
    dev_push(2, 8'h42);
    chk("irq_pre_rst", irq[2], 1'b1);
    @(posedge clk); #1;
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; adr[2] = 8'h05;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; cyc[2] = 1'b0; stb[2] = 1'b0;
    watch_no_ack(2, 6, "rst_no_ack");
    chk("rst2_ctrl", ctrl[2], 8'h00);
    chk("rst2_irq",  irq[2],  1'b0);
    chk("rst2_full", full[2], 1'b0);
    chk("rst2_dat",  rdat[2], 8'h00);
    rd(2, 8'h05, 8'h00);
    rd(2, 8'h03, 8'h01);
    rd(2, 8'h00, 8'h00);

    repeat (3) @(posedge clk);
    #1 chk("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
